// File: rtl/controlador_mul_div_4bits.sv
// Multi-cycle sequencer for 4-bit unsigned multiply (shift-and-add) and divide (restoring)
// that time-shares one external 5x4-bit add/subtract datapath.
module controlador_mul_div_4bits #(
  parameter logic [3:0] QUOC_DIV_ZERO = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       op_div,
  input  logic [3:0] op_x,
  input  logic [3:0] op_y,
  output logic [4:0] add_a,
  output logic [3:0] add_b,
  output logic       add_modo_sub,
  output logic       add_cin,
  input  logic [4:0] add_s,
  input  logic       add_cout,
  output logic       ocupado,
  output logic       pronto,
  output logic [7:0] resultado,
  output logic       div_zero
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  r_q, r_d;
  logic [3:0]  q_q, q_d;
  logic [3:0]  m_q, m_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        modo_q, modo_d;
  logic [7:0]  res_q, res_d;
  logic        dz_q, dz_d;
  logic [4:0]  sh;

  assign resultado = res_q;
  assign div_zero  = dz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      r_q     <= 4'd0;
      q_q     <= 4'd0;
      m_q     <= 4'd0;
      cnt_q   <= 2'd0;
      modo_q  <= 1'b0;
      res_q   <= 8'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      modo_q  <= modo_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    q_d          = q_q;
    m_d          = m_q;
    cnt_d        = cnt_q;
    modo_d       = modo_q;
    res_d        = res_q;
    dz_d         = dz_q;
    add_a        = 5'd0;
    add_b        = 4'd0;
    add_modo_sub = 1'b0;
    add_cin      = 1'b0;
    ocupado      = 1'b0;
    pronto       = 1'b0;
    sh           = {r_q, q_q[3]};

    unique case (state_q)
      StIdle: begin
        if (start) begin
          r_d    = 4'd0;
          q_d    = op_x;
          m_d    = op_y;
          modo_d = op_div;
          cnt_d  = 2'd0;
          if (op_div && (op_y == 4'd0)) begin
            // Divide-by-zero skips the datapath entirely and reports immediately.
            r_d     = op_x;
            q_d     = QUOC_DIV_ZERO;
            dz_d    = 1'b1;
            res_d   = {op_x, QUOC_DIV_ZERO};
            state_d = StDone;
          end else begin
            dz_d    = 1'b0;
            state_d = StCalc;
          end
        end
      end

      StCalc: begin
        ocupado = 1'b1;
        cnt_d   = cnt_q + 2'd1;
        if (!modo_q) begin
          add_a = {1'b0, r_q};
          add_b = q_q[0] ? m_q : 4'd0;
          r_d   = add_s[4:1];
          q_d   = {add_s[0], q_q[3:1]};
        end else begin
          add_a        = sh;
          add_b        = m_q;
          add_modo_sub = 1'b1;
          add_cin      = 1'b1;
          // Carry-out set means no borrow: the trial subtraction is kept.
          if (add_cout) begin
            r_d = add_s[3:0];
            q_d = {q_q[2:0], 1'b1};
          end else begin
            r_d = sh[3:0];
            q_d = {q_q[2:0], 1'b0};
          end
        end
        if (cnt_q == 2'd3) begin
          res_d   = {r_d, q_d};
          state_d = StDone;
        end
      end

      StDone: begin
        pronto  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_controlador_mul_div_4bits.sv
// Self-checking bench: models the external adder and checks results against plain
// arithmetic (x*y, x/y, x%y) with randomized and directed operands.
module tb_controlador_mul_div_4bits;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       op_div;
  logic [3:0] op_x;
  logic [3:0] op_y;
  logic [4:0] add_a;
  logic [3:0] add_b;
  logic       add_modo_sub;
  logic       add_cin;
  logic [4:0] add_s;
  logic       add_cout;
  logic       ocupado;
  logic       pronto;
  logic [7:0] resultado;
  logic       div_zero;

  int checks = 0;
  int errors = 0;

  // Per-step trace of adder controls captured during CALC cycles.
  logic [3:0] tr_b   [4];
  logic       tr_sub [4];
  logic       tr_cin [4];

  controlador_mul_div_4bits dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .op_div       (op_div),
    .op_x         (op_x),
    .op_y         (op_y),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_modo_sub (add_modo_sub),
    .add_cin      (add_cin),
    .add_s        (add_s),
    .add_cout     (add_cout),
    .ocupado      (ocupado),
    .pronto       (pronto),
    .resultado    (resultado),
    .div_zero     (div_zero)
  );

  // External adder: a + b + cin, or a + ~b + cin in subtract mode (cout = no borrow).
  logic [5:0] sum6;
  always_comb begin
    sum6 = {1'b0, add_a} + (add_modo_sub ? {1'b0, ~{1'b0, add_b}} : {2'b00, add_b})
           + {5'd0, add_cin};
  end
  assign add_s    = sum6[4:0];
  assign add_cout = sum6[5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic dv, input logic [3:0] x, input logic [3:0] y);
    int xi, yi;
    xi = int'(x);
    yi = int'(y);
    if (!dv) return 8'(xi * yi);
    if (yi == 0) return {x, 4'hF};
    return {4'(xi % yi), 4'(xi / yi)};
  endfunction

  task automatic do_op(input logic dv, input logic [3:0] x, input logic [3:0] y,
                       output logic [7:0] res, output logic dz, output int lat, output int busy);
    @(negedge clk);
    start  = 1'b1;
    op_div = dv;
    op_x   = x;
    op_y   = y;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    op_div = 1'($urandom);
    op_x   = 4'($urandom);
    op_y   = 4'($urandom);
    lat    = 1;
    busy   = 0;
    for (int i = 0; i < 4; i++) begin
      tr_b[i] = 4'hx; tr_sub[i] = 1'bx; tr_cin[i] = 1'bx;
    end
    while (pronto !== 1'b1 && lat < 20) begin
      if (ocupado === 1'b1) begin
        if (busy < 4) begin
          tr_b[busy]   = add_b;
          tr_sub[busy] = add_modo_sub;
          tr_cin[busy] = add_cin;
        end
        busy++;
      end
      @(negedge clk);
      lat++;
    end
    res = resultado;
    dz  = div_zero;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ocupado, pronto, div_zero, resultado, add_a, add_b, add_modo_sub, add_cin} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ocupado=%b pronto=%b dz=%b res=%h a=%h b=%h sub=%b cin=%b, expected all 0",
               ocupado, pronto, div_zero, resultado, add_a, add_b, add_modo_sub, add_cin);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [3:0] xs [3] = '{4'hD, 4'hF, 4'h0};
    logic [3:0] ys [3] = '{4'hB, 4'hF, 4'h9};
    logic [7:0] res;
    logic       dz;
    int         lat, busy;
    for (int t = 0; t < 3; t++) begin
      do_op(1'b0, xs[t], ys[t], res, dz, lat, busy);
      checks++;
      if (res !== model(1'b0, xs[t], ys[t])) begin
        errors++;
        $display("FAIL mul_result %0d: got %h expected %h", t, res, model(1'b0, xs[t], ys[t]));
      end
      checks++;
      if (dz !== 1'b0 || lat != 5 || busy != 4) begin
        errors++;
        $display("FAIL mul_timing %0d: got dz=%b lat=%0d busy=%0d expected dz=0 lat=5 busy=4",
                 t, dz, lat, busy);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (tr_b[i] !== (xs[t][i] ? ys[t] : 4'd0) || tr_sub[i] !== 1'b0 || tr_cin[i] !== 1'b0) begin
          errors++;
          $display("FAIL mul_step %0d.%0d: got b=%h sub=%b cin=%b expected b=%h sub=0 cin=0",
                   t, i, tr_b[i], tr_sub[i], tr_cin[i], xs[t][i] ? ys[t] : 4'd0);
        end
      end
      @(negedge clk);
      checks++;
      if (pronto !== 1'b0) begin
        errors++;
        $display("FAIL mul_pronto_pulse %0d: got pronto=%b expected 0", t, pronto);
      end
    end
  endtask

  task automatic test_div();
    logic [3:0] xs [2] = '{4'hD, 4'hF};
    logic [3:0] ys [2] = '{4'h4, 4'h1};
    logic [7:0] res;
    logic       dz;
    int         lat, busy;
    for (int t = 0; t < 2; t++) begin
      do_op(1'b1, xs[t], ys[t], res, dz, lat, busy);
      checks++;
      if (res !== model(1'b1, xs[t], ys[t]) || dz !== 1'b0 || lat != 5) begin
        errors++;
        $display("FAIL div_result %0d: got res=%h dz=%b lat=%0d expected res=%h dz=0 lat=5",
                 t, res, dz, lat, model(1'b1, xs[t], ys[t]));
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (tr_b[i] !== ys[t] || tr_sub[i] !== 1'b1 || tr_cin[i] !== 1'b1) begin
          errors++;
          $display("FAIL div_step %0d.%0d: got b=%h sub=%b cin=%b expected b=%h sub=1 cin=1",
                   t, i, tr_b[i], tr_sub[i], tr_cin[i], ys[t]);
        end
      end
    end
  endtask

  task automatic test_div_zero();
    logic [7:0] res;
    logic       dz;
    int         lat, busy;
    do_op(1'b1, 4'h7, 4'h0, res, dz, lat, busy);
    checks++;
    if (res !== model(1'b1, 4'h7, 4'h0) || dz !== 1'b1 || lat != 1 || busy != 0) begin
      errors++;
      $display("FAIL div_zero: got res=%h dz=%b lat=%0d busy=%0d expected res=%h dz=1 lat=1 busy=0",
               res, dz, lat, busy, model(1'b1, 4'h7, 4'h0));
    end
    do_op(1'b0, 4'h2, 4'h3, res, dz, lat, busy);
    checks++;
    if (res !== model(1'b0, 4'h2, 4'h3) || dz !== 1'b0 || lat != 5) begin
      errors++;
      $display("FAIL div_zero_clear: got res=%h dz=%b lat=%0d expected res=%h dz=0 lat=5",
               res, dz, lat, model(1'b0, 4'h2, 4'h3));
    end
  endtask

  task automatic test_start_ignored();
    int         npr = 0;
    logic [7:0] last = 8'h00;
    @(negedge clk);
    start = 1'b1; op_div = 1'b0; op_x = 4'hD; op_y = 4'hB;
    @(posedge clk);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (pronto === 1'b1) begin
        npr++;
        last = resultado;
      end
      start  = (n == 2 || n == 3 || n == 5);
      op_div = 1'b1;
      op_x   = 4'h5;
      op_y   = 4'h5;
    end
    start = 1'b0;
    checks++;
    if (npr != 1 || last !== model(1'b0, 4'hD, 4'hB)) begin
      errors++;
      $display("FAIL start_ignored: got %0d pronto res=%h expected 1 pronto res=%h",
               npr, last, model(1'b0, 4'hD, 4'hB));
    end
  endtask

  task automatic test_back_to_back();
    int         npr = 0;
    logic [7:0] last = 8'h00;
    logic [3:0] x, y;
    x = 4'($urandom);
    y = 4'($urandom_range(15, 1));
    @(negedge clk);
    start = 1'b1; op_div = 1'b1; op_x = x; op_y = y;
    @(posedge clk);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (pronto === 1'b1) begin
        npr++;
        last = resultado;
      end
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (npr != 2 || last !== model(1'b1, x, y)) begin
      errors++;
      $display("FAIL back_to_back: got %0d pronto res=%h expected 2 pronto res=%h",
               npr, last, model(1'b1, x, y));
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] res;
    logic       dz;
    int         lat, busy;
    int         npr = 0;
    do_op(1'b1, 4'h7, 4'h0, res, dz, lat, busy);
    @(negedge clk);
    start = 1'b1; op_div = 1'b0; op_x = 4'h9; op_y = 4'h9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ocupado, pronto, div_zero, resultado, add_a, add_b, add_modo_sub, add_cin} !== 21'd0) begin
      errors++;
      $display("FAIL reset_mid: got ocupado=%b pronto=%b dz=%b res=%h a=%h b=%h sub=%b cin=%b, expected all 0",
               ocupado, pronto, div_zero, resultado, add_a, add_b, add_modo_sub, add_cin);
    end
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (pronto === 1'b1) npr++;
    end
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (pronto === 1'b1) npr++;
    end
    checks++;
    if (npr != 0) begin
      errors++;
      $display("FAIL reset_abort: got %0d pronto expected 0", npr);
    end
    do_op(1'b0, 4'h3, 4'h5, res, dz, lat, busy);
    checks++;
    if (res !== model(1'b0, 4'h3, 4'h5) || lat != 5) begin
      errors++;
      $display("FAIL reset_recover: got res=%h lat=%0d expected res=%h lat=5",
               res, lat, model(1'b0, 4'h3, 4'h5));
    end
  endtask

  task automatic test_random();
    logic [7:0] res;
    logic       dz;
    int         lat, busy;
    logic       dv;
    logic [3:0] x, y;
    for (int t = 0; t < 40; t++) begin
      dv = 1'($urandom);
      x  = 4'($urandom);
      y  = ($urandom_range(7, 0) == 0) ? 4'd0 : 4'($urandom);
      do_op(dv, x, y, res, dz, lat, busy);
      checks++;
      if (res !== model(dv, x, y) || dz !== (dv && y == 4'd0) ||
          lat != ((dv && y == 4'd0) ? 1 : 5)) begin
        errors++;
        $display("FAIL random %0d (div=%b x=%h y=%h): got res=%h dz=%b lat=%0d expected res=%h dz=%b lat=%0d",
                 t, dv, x, y, res, dz, lat, model(dv, x, y), dv && y == 4'd0,
                 (dv && y == 4'd0) ? 1 : 5);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    op_div = 1'b0;
    op_x   = 4'd0;
    op_y   = 4'd0;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
